// File: rtl/relu_serializer.sv
// Latches one layer's parallel results, applies optional ReLU and streams them one per cycle, with one pending frame.
// Latency: capture edge t -> element 0 in cycle t+1; no backpressure, a capture arriving with both buffers full is dropped (o_drop).
module relu_serializer #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned NUM_NEURONS = 16,
  parameter bit          RELU_EN     = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_capture,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0]             dout,
  output logic                              o_valid,
  output logic                              o_first,
  output logic                              o_last,
  output logic                              o_drop,
  output logic                              busy
);

  localparam int unsigned IW = $clog2(NUM_NEURONS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURONS - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  state_t                            state_q;
  logic [IW-1:0]                     idx_q;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] act_q;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] pend_q;
  logic                              pend_vld_q;
  logic [DATA_WIDTH-1:0]             dout_q;
  logic                              valid_q;
  logic                              first_q;
  logic                              last_q;
  logic                              drop_q;
  logic                              busy_q;

  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] v);
    relu = (RELU_EN && v[DATA_WIDTH-1]) ? '0 : v;
  endfunction

  // Element 0 is registered straight from din on the capture edge so it
  // appears one cycle after capture; the GAP state emits the idle slot the
  // consuming cell needs after its last input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pend_vld_q <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      drop_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          dout_q  <= '0;
          valid_q <= 1'b0;
          first_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= i_capture;
          if (i_capture) begin
            act_q   <= din;
            dout_q  <= relu(din[DATA_WIDTH-1:0]);
            valid_q <= 1'b1;
            first_q <= 1'b1;
            idx_q   <= ONE_IDX;
            state_q <= STREAM;
          end
        end

        STREAM: begin
          dout_q  <= relu(act_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH]);
          valid_q <= 1'b1;
          first_q <= (idx_q == '0);
          last_q  <= (idx_q == LAST_IDX);
          busy_q  <= 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            state_q <= GAP;
          end else begin
            idx_q <= idx_q + ONE_IDX;
          end
          if (i_capture) begin
            if (pend_vld_q) begin
              drop_q <= 1'b1;
            end else begin
              pend_q     <= din;
              pend_vld_q <= 1'b1;
            end
          end
        end

        GAP: begin
          dout_q  <= '0;
          valid_q <= 1'b0;
          first_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b1;
          idx_q   <= '0;
          // Pending is freed and may be refilled by a capture on this same edge.
          if (pend_vld_q) begin
            act_q      <= pend_q;
            pend_vld_q <= i_capture;
            if (i_capture) begin
              pend_q <= din;
            end
            state_q <= STREAM;
          end else if (i_capture) begin
            act_q   <= din;
            state_q <= STREAM;
          end else begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          first_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dout    = dout_q;
  assign o_valid = valid_q;
  assign o_first = first_q;
  assign o_last  = last_q;
  assign o_drop  = drop_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_relu_serializer.sv
// Bench for relu_serializer (N=4, W=8): ReLU and pass-through instances share stimulus,
// checked against a frame-schedule model plus vector table and corner sequences.
module tb_relu_serializer;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int DW = N * W;
  localparam int LOGN = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_capture = 1'b0;
  logic [DW-1:0] din = '0;

  logic [W-1:0] dout1, dout0;
  logic v1, f1, l1, d1, b1;
  logic v0, f0, l0, d0, b0;

  relu_serializer #(.DATA_WIDTH(W), .NUM_NEURONS(N), .RELU_EN(1'b1)) u_relu (
    .clk(clk), .rst(rst), .i_capture(i_capture), .din(din),
    .dout(dout1), .o_valid(v1), .o_first(f1), .o_last(l1), .o_drop(d1), .busy(b1)
  );

  relu_serializer #(.DATA_WIDTH(W), .NUM_NEURONS(N), .RELU_EN(1'b0)) u_pass (
    .clk(clk), .rst(rst), .i_capture(i_capture), .din(din),
    .dout(dout0), .o_valid(v0), .o_first(f0), .o_last(l0), .o_drop(d0), .busy(b0)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cap;
    int            start;
    logic [DW-1:0] data;
  } frame_t;

  typedef struct {
    logic          cap;
    logic [DW-1:0] d;
    logic          ev, ef, el, ed, eb;
    logic [W-1:0]  e1, e0;
  } vec_t;

  frame_t frames[$];
  int     drop_cyc = -1;
  int     cyc = 0;
  int     total = 0;
  int     bad = 0;

  logic         lv[LOGN], lf[LOGN], ll[LOGN], ld[LOGN], lb[LOGN];
  logic [W-1:0] ldo0[LOGN];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endfunction

  // Schedule view: each accepted frame occupies [start, start+N-1], followed by
  // one idle cycle; a frame still waiting to be moved into the active buffer
  // (moved two cycles before it starts) blocks any further capture.
  function automatic void model_edge(int e, logic cap, logic rn, logic [DW-1:0] d);
    frame_t f;
    int     last_end;
    if (!rn) begin
      frames.delete();
      drop_cyc = -1;
      return;
    end
    if (!cap) return;
    if (frames.size() > 0 && frames[frames.size()-1].start - 2 > e) begin
      drop_cyc = e + 1;
      return;
    end
    last_end = (frames.size() > 0) ? frames[frames.size()-1].start + N - 1 : -100;
    f.cap   = e;
    f.start = (e + 1 > last_end + 2) ? e + 1 : last_end + 2;
    f.data  = d;
    frames.push_back(f);
  endfunction

  task automatic check_cycle();
    logic         ev, ef, el, ed, eb;
    logic [W-1:0] e1, e0, v;
    int           k;
    ev = 1'b0; ef = 1'b0; el = 1'b0; eb = 1'b0; e1 = '0; e0 = '0;
    while (frames.size() > 0 && frames[0].start + N < cyc) void'(frames.pop_front());
    foreach (frames[i]) begin
      if (cyc >= frames[i].start && cyc < frames[i].start + N) begin
        k  = cyc - frames[i].start;
        v  = frames[i].data[k*W +: W];
        ev = 1'b1;
        ef = (k == 0);
        el = (k == N - 1);
        e0 = v;
        e1 = v[W-1] ? '0 : v;
      end
      if (frames[i].cap < cyc && cyc <= frames[i].start + N) eb = 1'b1;
    end
    ed = (drop_cyc == cyc);
    chk("m_valid1", v1, ev);   chk("m_valid0", v0, ev);
    chk("m_first1", f1, ef);   chk("m_first0", f0, ef);
    chk("m_last1",  l1, el);   chk("m_last0",  l0, el);
    chk("m_drop1",  d1, ed);   chk("m_drop0",  d0, ed);
    chk("m_busy1",  b1, eb);   chk("m_busy0",  b0, eb);
    chk("m_dout1",  dout1, e1);
    chk("m_dout0",  dout0, e0);
  endtask

  task automatic step(input logic cap, input logic [DW-1:0] d, input logic rn);
    i_capture = cap;
    din       = d;
    rst       = rn;
    @(posedge clk);
    model_edge(cyc, cap, rn, d);
    cyc++;
    #1;
    if (cyc < LOGN) begin
      lv[cyc] = v1; lf[cyc] = f1; ll[cyc] = l1; ld[cyc] = d1; lb[cyc] = b1;
      ldo0[cyc] = dout0;
    end
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
  endtask

  function automatic int count_first(input int a, input int z);
    int c = 0;
    for (int i = a; i <= z; i++) if (lf[i]) c++;
    return c;
  endfunction

  function automatic int count_drop(input int a, input int z);
    int c = 0;
    for (int i = a; i <= z; i++) if (ld[i]) c++;
    return c;
  endfunction

  localparam logic [DW-1:0] FR = 32'h807FFD05;
  localparam logic [DW-1:0] FA = 32'h04030201;
  localparam logic [DW-1:0] FB = 32'h14131211;
  localparam logic [DW-1:0] FC = 32'h24232221;
  localparam logic [DW-1:0] FD = 32'h34333231;

  vec_t tbl[6];
  int   b;

  initial begin
    tbl[0] = '{1'b1, FR, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 8'h05};
    tbl[1] = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hFD};
    tbl[2] = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7F, 8'h7F};
    tbl[3] = '{1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h80};
    tbl[4] = '{1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
    tbl[5] = '{1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};

    // reset state
    step(1'b0, '0, 1'b0);
    step(1'b1, FA, 1'b0);
    chk("rst_valid", v1, 0);
    chk("rst_busy", b1, 0);
    chk("rst_dout", dout1, 0);
    idle(3);

    // single frame, both ReLU settings
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].cap, tbl[i].d, 1'b1);
      chk("tbl_valid", v1, tbl[i].ev);
      chk("tbl_first", f1, tbl[i].ef);
      chk("tbl_last",  l1, tbl[i].el);
      chk("tbl_drop",  d1, tbl[i].ed);
      chk("tbl_busy",  b1, tbl[i].eb);
      chk("tbl_dout_relu", dout1, tbl[i].e1);
      chk("tbl_dout_pass", dout0, tbl[i].e0);
    end
    idle(3);

    // two captures at 0 and 2
    b = cyc;
    step(1'b1, FA, 1'b1); step(1'b0, '0, 1'b1); step(1'b1, FB, 1'b1);
    idle(10);
    chk("two_lastA", ll[b+4], 1);
    chk("two_gap", lv[b+5], 0);
    chk("two_firstB", lf[b+6], 1);
    chk("two_B0", ldo0[b+6], 8'h11);
    chk("two_lastB", ll[b+9], 1);
    chk("two_nodrop", count_drop(b+1, b+12), 0);

    // three captures at 0,1,2
    b = cyc;
    step(1'b1, FA, 1'b1); step(1'b1, FB, 1'b1); step(1'b1, FC, 1'b1);
    idle(12);
    chk("three_drop3", ld[b+3], 1);
    chk("three_dropcnt", count_drop(b+1, b+14), 1);
    chk("three_firstB", lf[b+6], 1);
    chk("three_frames", count_first(b+1, b+14), 2);
    chk("three_noC", lv[b+11], 0);

    // capture C on the GAP edge while B pending
    b = cyc;
    step(1'b1, FA, 1'b1); step(1'b0, '0, 1'b1); step(1'b1, FB, 1'b1);
    step(1'b0, '0, 1'b1); step(1'b1, FC, 1'b1);
    idle(14);
    chk("gap_firstB", lf[b+6], 1);
    chk("gap_lastB", ll[b+9], 1);
    chk("gap_idle10", lv[b+10], 0);
    chk("gap_firstC", lf[b+11], 1);
    chk("gap_C0", ldo0[b+11], 8'h21);
    chk("gap_lastC", ll[b+14], 1);
    chk("gap_nodrop", count_drop(b+1, b+18), 0);

    // reset mid-stream with a frame pending
    b = cyc;
    step(1'b1, FA, 1'b1); step(1'b1, FB, 1'b1); step(1'b0, '0, 1'b0);
    idle(3);
    chk("rstm_valid", lv[b+3], 0);
    chk("rstm_busy", lb[b+3], 0);
    step(1'b1, FD, 1'b1);
    idle(10);
    chk("rstm_firstD", lf[b+7], 1);
    chk("rstm_D0", ldo0[b+7], 8'h31);
    chk("rstm_frames", count_first(b+3, b+16), 1);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 2) == 0), DW'($urandom), ($urandom_range(0, 199) != 0));
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
